// File: rtl/board_plotter.sv
// Board renderer: scans 64 cells and draws each as a filled CELL x CELL square, one pixel per cycle.
// Optional build macro CURSOR_HILITE_EN adds a cursor whose cell border is drawn in red.
module board_plotter #(
  parameter int ORIGIN_X = 9,
  parameter int ORIGIN_Y = 9,
  parameter int PITCH    = 13,
  parameter int CELL     = 12
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [1:0] cell_q,
`ifdef CURSOR_HILITE_EN
  input  logic [2:0] cursor_x,
  input  logic [2:0] cursor_y,
`endif
  output logic [2:0] cell_x,
  output logic [2:0] cell_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_DRAW  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [3:0] LAST    = 4'(CELL - 1);

  logic [2:0] r_state;
  logic [2:0] r_cell_x, r_cell_y;
  logic [3:0] r_px, r_py;
  logic [2:0] r_colour;
  logic [7:0] r_vga_x;
  logic [6:0] r_vga_y;
  logic [2:0] r_vga_colour;
  logic       r_plot, r_busy, r_done;
  logic [7:0] w_x;
  logic [6:0] w_y;
  logic [2:0] w_pix_colour;

  function automatic logic [2:0] f_colour(input logic [1:0] q);
    case (q)
      2'd2:    f_colour = 3'b000;
      2'd3:    f_colour = 3'b111;
      default: f_colour = 3'b010;
    endcase
  endfunction

  // vga_y only needs 7 bits, so it is computed modulo 128 directly
  assign w_x = 8'(ORIGIN_X) + 8'(r_cell_x) * 8'(PITCH) + 8'(r_px);
  assign w_y = 7'(ORIGIN_Y) + 7'(r_cell_y) * 7'(PITCH) + 7'(r_py);

`ifdef CURSOR_HILITE_EN
  logic r_hilite;
  logic w_border;
  assign w_border     = (r_px == 4'd0) || (r_px == LAST) || (r_py == 4'd0) || (r_py == LAST);
  assign w_pix_colour = (r_hilite && w_border) ? 3'b100 : r_colour;
`else
  assign w_pix_colour = r_colour;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_cell_x     <= 3'd0;
      r_cell_y     <= 3'd0;
      r_px         <= 4'd0;
      r_py         <= 4'd0;
      r_colour     <= 3'd0;
      r_vga_x      <= 8'd0;
      r_vga_y      <= 7'd0;
      r_vga_colour <= 3'd0;
      r_plot       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef CURSOR_HILITE_EN
      r_hilite     <= 1'b0;
`endif
    end else begin
      r_plot <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_busy <= start;
          if (start) begin
            r_state  <= S_ADDR;
            r_cell_x <= 3'd0;
            r_cell_y <= 3'd0;
          end
        end
        S_ADDR: r_state <= S_LATCH;
        S_LATCH: begin
          r_colour <= f_colour(cell_q);
`ifdef CURSOR_HILITE_EN
          r_hilite <= (r_cell_x == cursor_x) && (r_cell_y == cursor_y);
`endif
          r_px    <= 4'd0;
          r_py    <= 4'd0;
          r_state <= S_DRAW;
        end
        S_DRAW: begin
          r_plot       <= 1'b1;
          r_vga_x      <= w_x;
          r_vga_y      <= w_y;
          r_vga_colour <= w_pix_colour;
          if (r_px == LAST) begin
            r_px <= 4'd0;
            if (r_py == LAST) begin
              if (r_cell_x == 3'd7 && r_cell_y == 3'd7) begin
                r_state <= S_DONE;
              end else begin
                r_cell_x <= r_cell_x + 3'd1;
                if (r_cell_x == 3'd7) r_cell_y <= r_cell_y + 3'd1;
                r_state <= S_ADDR;
              end
            end else begin
              r_py <= r_py + 4'd1;
            end
          end else begin
            r_px <= r_px + 4'd1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cell_x     = r_cell_x;
  assign cell_y     = r_cell_y;
  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_colour;
  assign vga_plot   = r_plot;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_board_plotter.sv
// Randomized bench for board_plotter with a frame-timeline reference model.
module tb_board_plotter;
  localparam int OX = 9, OY = 9, PT = 13, CL = 12;
  localparam int PER   = 2 + CL * CL;     // cycles per cell
  localparam int FRAME = 64 * PER + 1;    // acceptance edge to done edge
`ifdef CURSOR_HILITE_EN
  localparam int RED_EXP = 44;
`else
  localparam int RED_EXP = 0;
`endif

  logic       clock = 1'b0;
  logic       resetn, start;
  logic [1:0] cell_q;
  logic [2:0] cell_x, cell_y, vga_colour;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic       vga_plot, busy, done;
  logic [1:0] board [64];
`ifdef CURSOR_HILITE_EN
  logic [2:0] cursor_x = 3'd7;
  logic [2:0] cursor_y = 3'd7;
`endif

  board_plotter dut (
    .clock(clock), .resetn(resetn), .start(start), .cell_q(cell_q),
`ifdef CURSOR_HILITE_EN
    .cursor_x(cursor_x), .cursor_y(cursor_y),
`endif
    .cell_x(cell_x), .cell_y(cell_y), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;
  assign cell_q = board[{cell_y, cell_x}];

  int checks = 0, failures = 0;
  int cyc = 0, m_k = 0;
  bit m_active = 0;
  logic [2:0] exp_col [64];
  bit exp_hil [64];
  int plot_cnt, done_cnt, red_cnt, non_empty_cnt, last_done_cyc;
  bit cap_en = 0;
  int cap_x [6], cap_y [6], cap_c [6];
  bit first_seen;
  int first_x, first_y;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [2:0] cmap(input logic [1:0] q);
    return (q == 2'd2) ? 3'b000 : (q == 2'd3) ? 3'b111 : 3'b010;
  endfunction

  // Reference model: position in the frame timeline determines every output.
  always @(posedge clock) begin
    int c, i, px, py, slot;
    bit e_plot;
    cyc++;
    if (!resetn) begin
      m_active = 0; m_k = 0;
    end else if ((!m_active || m_k == FRAME) && start) begin
      m_active = 1; m_k = 0;
    end else if (m_active) begin
      if (m_k == FRAME) m_active = 0; else m_k++;
    end
    if (m_active && m_k >= 2 && (m_k - 2) % PER == 0 && (m_k - 2) / PER < 64) begin
      c = (m_k - 2) / PER;
      exp_col[c] = cmap(board[c]);
`ifdef CURSOR_HILITE_EN
      exp_hil[c] = (c % 8 == int'(cursor_x)) && (c / 8 == int'(cursor_y));
`else
      exp_hil[c] = 0;
`endif
    end
    #1;
    e_plot = 0; c = 0; i = 0;
    if (m_active && m_k >= 3) begin
      c = (m_k - 3) / PER; i = (m_k - 3) % PER;
      e_plot = (i < CL * CL) && (c < 64);
    end
    chk("plot", vga_plot, e_plot);
    chk("busy", busy, m_active);
    chk("done", done, m_active && m_k == FRAME);
    if (m_active) begin
      chk("cell_x", cell_x, ((m_k / PER > 63) ? 63 : m_k / PER) % 8);
      chk("cell_y", cell_y, ((m_k / PER > 63) ? 63 : m_k / PER) / 8);
    end
    if (e_plot) begin
      px = i % CL; py = i / CL;
      chk("vga_x", vga_x, OX + (c % 8) * PT + px);
      chk("vga_y", vga_y, OY + (c / 8) * PT + py);
      chk("colour", vga_colour,
          (exp_hil[c] && (px == 0 || py == 0 || px == CL - 1 || py == CL - 1)) ? 4 : int'(exp_col[c]));
      if (cap_en) begin
        slot = -1;
        if (c == 0)  slot = 0;
        if (c == 27) slot = 2;
        if (c == 28) slot = 4;
        if (slot >= 0 && (i == 0 || i == CL * CL - 1)) begin
          if (i != 0) slot++;
          cap_x[slot] = vga_x; cap_y[slot] = vga_y; cap_c[slot] = vga_colour;
        end
      end
    end
    if (vga_plot) begin
      plot_cnt++;
      if (vga_colour == 3'b100) red_cnt++;
      if (vga_colour != 3'b010) non_empty_cnt++;
      if (!first_seen) begin first_seen = 1; first_x = vga_x; first_y = vga_y; end
    end
    if (done) begin done_cnt++; last_done_cyc = cyc; end
  end

  task automatic clear_counts();
    plot_cnt = 0; done_cnt = 0; red_cnt = 0; non_empty_cnt = 0; first_seen = 0;
  endtask

  task automatic wait_done(input bit mutate);
    int n = 0;
    while (done_cnt == 0 && n < FRAME + 200) begin
      @(negedge clock);
      if (mutate) board[$urandom_range(63)] = 2'($urandom);
      n++;
    end
    if (done_cnt == 0) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_k(input int k);
    int n = 0;
    while (!(m_active && m_k == k) && n < FRAME + 200) begin
      @(negedge clock); n++;
    end
    if (!(m_active && m_k == k)) chk("k_timeout", m_k, k);
  endtask

  initial begin
    int s_cyc;
    resetn = 0; start = 0;
    for (int j = 0; j < 64; j++) board[j] = 2'd0;
    board[27] = 2'd2; board[36] = 2'd2; board[28] = 2'd3; board[35] = 2'd3;
    repeat (3) @(negedge clock);
    chk("rst_x", vga_x, 0);   chk("rst_y", vga_y, 0);   chk("rst_col", vga_colour, 0);
    chk("rst_cx", cell_x, 0); chk("rst_cy", cell_y, 0); chk("rst_plot", vga_plot, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    resetn = 1;
    repeat (2) @(negedge clock);

    // Initial board setup, single-cycle start
    clear_counts(); cap_en = 1;
    chk("busy_before", busy, 0);
    start = 1; s_cyc = cyc + 1;
    @(negedge clock); start = 0;
    wait_done(0);
    cap_en = 0;
    chk("f1_plots", plot_cnt, 9216);
    chk("f1_done_cyc", last_done_cyc - s_cyc, 9345);
    chk("f1_red", red_cnt, RED_EXP);
    chk("c0_first_x", cap_x[0], 9);   chk("c0_first_y", cap_y[0], 9);   chk("c0_col", cap_c[0], 2);
    chk("c0_last_x", cap_x[1], 20);   chk("c0_last_y", cap_y[1], 20);
    chk("c27_first_x", cap_x[2], 48); chk("c27_first_y", cap_y[2], 48); chk("c27_col", cap_c[2], 0);
    chk("c27_last_x", cap_x[3], 59);  chk("c27_last_y", cap_y[3], 59);  chk("c27_lcol", cap_c[3], 0);
    chk("c28_first_x", cap_x[4], 61); chk("c28_col", cap_c[4], 7);
    chk("c28_last_x", cap_x[5], 72);  chk("c28_last_y", cap_y[5], 59);
    repeat (3) @(negedge clock);
    chk("busy_after", busy, 0);

    // All cells code 1, second start at cycle 500 must be ignored
    for (int j = 0; j < 64; j++) board[j] = 2'd1;
    clear_counts();
    start = 1; @(negedge clock); start = 0;
    wait_k(500);
    start = 1; @(negedge clock); start = 0;
    wait_done(0);
    repeat (5) @(negedge clock);
    chk("f2_done_cnt", done_cnt, 1);
    chk("f2_plots", plot_cnt, 9216);
    chk("f2_non_empty", non_empty_cnt, RED_EXP);

    // Random board, reset at cycle 2000, then redraw while the board changes
    for (int j = 0; j < 64; j++) board[j] = 2'($urandom);
    clear_counts();
    start = 1; @(negedge clock); start = 0;
    wait_k(2000);
    resetn = 0; @(negedge clock); resetn = 1;
    chk("mid_rst_plot", vga_plot, 0); chk("mid_rst_busy", busy, 0);
    chk("mid_rst_x", vga_x, 0);       chk("mid_rst_cx", cell_x, 0);
    repeat (200) @(negedge clock);
    chk("mid_rst_no_done", done_cnt, 0);
    clear_counts();
    start = 1; @(negedge clock); start = 0;
    wait_done(1);
    chk("f3_first_x", first_x, 9); chk("f3_first_y", first_y, 9);
    chk("f3_plots", plot_cnt, 9216);

    // start held high: a new frame begins right after DONE
    clear_counts();
    start = 1;
    wait_done(1);
    wait_k(200);
    chk("held_done_cnt", done_cnt, 1);
    chk("held_restarted", int'(plot_cnt > 9216), 1);
    start = 0; resetn = 0;
    @(negedge clock); resetn = 1;
    repeat (3) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/board_plotter.md
Name: board_plotter

Overview:
- Downstream render stage for the board RAM.
- On a start pulse it scans all 64 cells in row-major order. For each cell it presents the cell address to the board, captures the 2-bit cell code, and draws a filled square of pixels into the VGA adapter, one pixel per cycle.
- It replaces free-running plot logic with a deterministic, handshaked FSM.

Parameters:
- ORIGIN_X, 9, pixel x of the top-left corner of cell (0,0)
- ORIGIN_Y, 9, pixel y of the top-left corner of cell (0,0)
- PITCH, 13, pixel distance between adjacent cell origins
- CELL, 12, side length of the drawn square in pixels (CELL <= PITCH, CELL <= 16)

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  reset; synchronous, active-low
- start  in  1  request a full-board redraw; sampled in IDLE only
- cell_q  in  2  cell code from the board for the presented address
- cell_x  out  3  board column being read
- cell_y  out  3  board row being read
- vga_x  out  8  pixel x to the VGA adapter
- vga_y  out  7  pixel y to the VGA adapter
- vga_colour  out  3  pixel colour
- vga_plot  out  1  write strobe for the pixel on vga_x/vga_y
- busy  out  1  high from the first cycle after an accepted start through the DONE cycle
- done  out  1  one-cycle pulse when the last pixel of cell 63 has been plotted

Behaviour:
- Reset (resetn=0 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0: cell_x, cell_y, vga_x, vga_y, vga_colour, vga_plot, busy, done.
  - Pixel counters px and py go to 0.
  - Reset mid-scan abandons the frame: no done pulse, no further plots.
- Colour map from cell_q:
  - 2'd0 or 2'd1 → 3'b010 (empty)
  - 2'd2 → 3'b000 (side 0)
  - 2'd3 → 3'b111 (side 1)
- IDLE:
  - busy=0, vga_plot=0.
  - start=1 → ADDR with cell_x=cell_y=0.
- ADDR (1 cycle): cell_x/cell_y are held stable for the board's combinational read. Next state is LATCH.
- LATCH (1 cycle):
  - Register the colour from cell_q.
  - Set px=py=0.
  - Next state is DRAW.
- DRAW (CELL*CELL cycles):
  - Every cycle: vga_plot=1, vga_x = ORIGIN_X + cell_x*PITCH + px, vga_y = ORIGIN_Y + cell_y*PITCH + py, vga_colour = latched colour.
  - The vga outputs are registered in the same state, so they are valid while vga_plot=1.
  - px increments fastest. At px=CELL-1, px wraps to 0 and py increments.
  - At px=py=CELL-1: if the cell is the last one (cell_x=cell_y=7), go to DONE. Otherwise advance cell_x (wrapping 7→0 and incrementing cell_y) and go to ADDR.
  - vga_plot deasserts in ADDR and LATCH.
- DONE (1 cycle): done=1, busy=1, vga_plot=0. Next state is IDLE.
- Arithmetic and widths:
  - Compute at 8 bits.
  - vga_y takes the low 7 bits.
  - Default maximum pixel is x = y = 9 + 7*13 + 11 = 111, so there is no overflow.
- Timing: with start accepted at edge 0, the first plot is valid after edge 3. Total frame is 64*(2 + CELL*CELL) + 1 cycles to done (9345 with defaults).
- Start handling:
  - start while busy is ignored; no queueing.
  - start held high continuously restarts a frame in the cycle after DONE.
- cell_q is only sampled in LATCH. Board changes during DRAW do not affect the cell being drawn.

Optional Feature:
- Macro: CURSOR_HILITE_EN
- Defined:
  - Adds inputs cursor_x[2:0] and cursor_y[2:0], sampled in LATCH.
  - When the current cell equals the cursor, border pixels (px or py equal to 0 or CELL-1) are drawn in 3'b100. Interior pixels use the normal map.
- Undefined: the ports are absent and all pixels use the normal map.

Test Plan:
- Reset, then a 1-cycle start with the board at its initial setup (cells 27,36=2; 28,35=3; others 0) → exactly 9216 vga_plot pulses; done at cycle 9345; busy low before and after.
- Same frame, check cell 27 (x=3,y=3) → 144 plots with x in 48..59, y in 48..59, colour 000. Cell 28 → x in 61..72, colour 111. Cell 0 → x,y in 9..20, colour 010.
- cell_q=1 for all cells → every plot uses colour 010.
- start pulsed again at cycle 500 of a frame → ignored; only one done pulse; plot count unchanged.
- resetn=0 at cycle 2000 → next cycle vga_plot=0, busy=0, and no done; a new start redraws from cell (0,0).
- CURSOR_HILITE_EN with cursor (7,7) → the cell 63 border, 44 pixels, is 100 and its 100 interior pixels use the normal map. All other cells are unaffected.
